// File: rtl/ad9837_pkg.sv
// Shared types and register-word constants for the AD9837 configuration sequencer.
package ad9837_pkg;

  typedef enum logic [2:0] {FrIdle, FrSetup, FrShiftLo, FrShiftHi, FrTail} frame_state_e;
  typedef enum logic [1:0] {StIdle, StFrame, StGap, StDone} ctrl_state_e;

  localparam logic [15:0] CTRL_RESET  = 16'h2100;
  localparam logic [15:0] CTRL_RUN    = 16'h2000;
  localparam logic [15:0] FREQ0_SEL   = 16'h4000;
  localparam logic [15:0] PHASE0_WORD = 16'hC000;

  localparam logic [15:0] WAVE_SINE     = 16'h0000;
  localparam logic [15:0] WAVE_TRIANGLE = 16'h0002;
  localparam logic [15:0] WAVE_SQUARE   = 16'h0028;
  localparam logic [15:0] WAVE_SQ_HALF  = 16'h0020;

  localparam int unsigned NUM_WORDS = 5;

  function automatic logic [15:0] wave_bits(input logic [1:0] sel);
    case (sel)
      2'd0:    return WAVE_SINE;
      2'd1:    return WAVE_TRIANGLE;
      2'd2:    return WAVE_SQUARE;
      default: return WAVE_SQ_HALF;
    endcase
  endfunction

  function automatic logic [15:0] cfg_word(input logic [2:0] idx, input logic [27:0] freq,
                                           input logic [1:0] wave);
    case (idx)
      3'd0:    return CTRL_RESET;
      3'd1:    return FREQ0_SEL | {2'b00, freq[13:0]};
      3'd2:    return FREQ0_SEL | {2'b00, freq[27:14]};
      3'd3:    return PHASE0_WORD;
      default: return CTRL_RUN | wave_bits(wave);
    endcase
  endfunction

endpackage

// File: rtl/ad9837_spi_frame.sv
// Shifts one 16-bit word out on SCLK/FSYNC/SDATA, MSB first; ack marks the last TAIL cycle.
module ad9837_spi_frame
  import ad9837_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] word,
  output logic        ack,
  output logic        sclk,
  output logic        fsync,
  output logic        sdata
);

  localparam logic [7:0] HpLast = 8'(CLK_DIV - 1);

  frame_state_e state_q, state_d;
  logic [7:0]   hp_q, hp_d;
  logic [3:0]   bit_q, bit_d;
  logic [15:0]  shreg_q, shreg_d;
  logic         sclk_q, sclk_d, fsync_q, fsync_d, sdata_q, sdata_d;
  logic         hp_last;

  assign hp_last = (hp_q == HpLast);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = sclk_q;
    fsync_d = fsync_q;
    sdata_d = sdata_q;
    if (state_q != FrIdle) hp_d = hp_last ? 8'd0 : hp_q + 8'd1;
    case (state_q)
      FrIdle: if (load) begin
        state_d = FrSetup;
        hp_d    = 8'd0;
        bit_d   = 4'd15;
        shreg_d = word;
        fsync_d = 1'b0;
        sclk_d  = 1'b1;
        sdata_d = word[15];
      end
      FrSetup: if (hp_last) begin
        state_d = FrShiftLo;
        sclk_d  = 1'b0;
      end
      FrShiftLo: if (hp_last) begin
        sclk_d = 1'b1;
        if (bit_q == 4'd0) begin
          state_d = FrTail;
        end else begin
          // Data moves only on the rising edge, half a period clear of the next fall.
          state_d = FrShiftHi;
          bit_d   = bit_q - 4'd1;
          shreg_d = {shreg_q[14:0], 1'b0};
          sdata_d = shreg_q[14];
        end
      end
      FrShiftHi: if (hp_last) begin
        state_d = FrShiftLo;
        sclk_d  = 1'b0;
      end
      FrTail: if (hp_last) begin
        state_d = FrIdle;
        fsync_d = 1'b1;
        sdata_d = 1'b0;
      end
      default: state_d = FrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FrIdle;
      hp_q    <= 8'd0;
      bit_q   <= 4'd0;
      shreg_q <= 16'd0;
      sclk_q  <= 1'b1;
      fsync_q <= 1'b1;
      sdata_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      fsync_q <= fsync_d;
      sdata_q <= sdata_d;
    end
  end

  assign ack   = (state_q == FrTail) && hp_last;
  assign sclk  = sclk_q;
  assign fsync = fsync_q;
  assign sdata = sdata_q;

endmodule

// File: rtl/ad9837_cfg_ctrl.sv
// Runs the five-word AD9837 programming sequence: word selection, inter-frame gap, busy/done.
module ad9837_cfg_ctrl
  import ad9837_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [27:0] freq_in,
  input  logic [1:0]  wave_sel,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        fsync,
  output logic        sdata
);

  localparam logic [7:0] GapLast = 8'(IDLE_GAP - 1);
  localparam logic [2:0] LastIdx = 3'(NUM_WORDS - 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  widx_q, widx_d, word_sel;
  logic [7:0]  gap_q, gap_d;
  logic [27:0] freq_q, freq_d;
  logic [1:0]  wave_q, wave_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        load, frame_ack;
  logic [15:0] word;

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    gap_d    = gap_q;
    freq_d   = freq_q;
    wave_d   = wave_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;
    word_sel = widx_q + 3'd1;
    case (state_q)
      // DONE accepts too, so a held start restarts without an extra idle cycle.
      StIdle, StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = StFrame;
          widx_d   = 3'd0;
          word_sel = 3'd0;
          freq_d   = freq_in;
          wave_d   = wave_sel;
          busy_d   = 1'b1;
          load     = 1'b1;
        end
      end
      StFrame: if (frame_ack) begin
        state_d = StGap;
        gap_d   = 8'd0;
      end
      StGap: begin
        if (gap_q != GapLast) begin
          gap_d = gap_q + 8'd1;
        end else if (widx_q == LastIdx) begin
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = StFrame;
          widx_d  = word_sel;
          load    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Word 0 is a constant, so feeding it before freq/wave are latched is safe.
  assign word = cfg_word(word_sel, freq_q, wave_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      widx_q  <= 3'd0;
      gap_q   <= 8'd0;
      freq_q  <= 28'd0;
      wave_q  <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      gap_q   <= gap_d;
      freq_q  <= freq_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  ad9837_spi_frame #(
    .CLK_DIV (CLK_DIV)
  ) u_frame (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .word  (word),
    .ack   (frame_ack),
    .sclk  (sclk),
    .fsync (fsync),
    .sdata (sdata)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ad9837_cfg_ctrl.sv
// Bench for ad9837_cfg_ctrl: an SPI-slave monitor and a word model check two parameterisations.
module tb_ad9837_cfg_ctrl;

  localparam int HD = 4, GD = 2, HF = 1, GF = 1;
  localparam int TD = 5 * (33 * HD + GD) + 1;
  localparam int TF = 5 * (33 * HF + GF) + 1;

  logic clk = 1'b0, rst = 1'b1, start_r = 1'b0, mon_sel = 1'b0;
  logic [27:0] freq_in = 28'd0;
  logic [1:0]  wave_sel = 2'd0;
  logic start_d, start_f;
  logic busy_d, done_d, sclk_d, fsync_d, sdata_d;
  logic busy_f, done_f, sclk_f, fsync_f, sdata_f;
  logic m_busy, m_done, m_sclk, m_fsync, m_sdata;

  int checks = 0, errors = 0;
  int wave_tab[4] = '{0, 2, 40, 32};
  logic [15:0] cap_words[$];
  int cap_falls[$], cap_low[$];
  logic [15:0] exp_words[$];

  always #5 clk = ~clk;

  assign start_d = start_r & ~mon_sel;
  assign start_f = start_r & mon_sel;
  assign m_busy  = mon_sel ? busy_f : busy_d;
  assign m_done  = mon_sel ? done_f : done_d;
  assign m_sclk  = mon_sel ? sclk_f : sclk_d;
  assign m_fsync = mon_sel ? fsync_f : fsync_d;
  assign m_sdata = mon_sel ? sdata_f : sdata_d;

  ad9837_cfg_ctrl dut (
    .clk(clk), .rst(rst), .freq_in(freq_in), .wave_sel(wave_sel), .start(start_d),
    .busy(busy_d), .done(done_d), .sclk(sclk_d), .fsync(fsync_d), .sdata(sdata_d)
  );

  ad9837_cfg_ctrl #(.CLK_DIV(HF), .IDLE_GAP(GF)) dut_f (
    .clk(clk), .rst(rst), .freq_in(freq_in), .wave_sel(wave_sel), .start(start_f),
    .busy(busy_f), .done(done_f), .sclk(sclk_f), .fsync(fsync_f), .sdata(sdata_f)
  );

  // SPI slave: samples sdata on each sclk fall while fsync is low.
  initial begin
    logic prev_sclk;
    logic in_frame;
    logic [15:0] sh;
    int nf, low;
    prev_sclk = 1'b1; in_frame = 1'b0; sh = 16'd0; nf = 0; low = 0;
    forever begin
      @(negedge clk);
      if (m_fsync === 1'b0) begin
        if (!in_frame) begin
          in_frame = 1'b1; sh = 16'd0; nf = 0; low = 0;
        end
        low++;
        if (prev_sclk === 1'b1 && m_sclk === 1'b0) begin
          sh = {sh[14:0], m_sdata};
          nf++;
        end
      end else if (in_frame) begin
        cap_words.push_back(sh);
        cap_falls.push_back(nf);
        cap_low.push_back(low);
        in_frame = 1'b0;
      end
      prev_sclk = m_sclk;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] model_word(input int idx, input logic [27:0] f,
                                             input logic [1:0] w);
    int fi = int'(f);
    case (idx)
      0:       return 16'h2100;
      1:       return 16'(32'h4000 + fi % 16384);
      2:       return 16'(32'h4000 + fi / 16384);
      3:       return 16'hC000;
      default: return 16'(32'h2000 + wave_tab[w]);
    endcase
  endfunction

  task automatic clear_caps();
    cap_words.delete(); cap_falls.delete(); cap_low.delete(); exp_words.delete();
  endtask

  task automatic add_model(input logic [27:0] f, input logic [1:0] w);
    for (int i = 0; i < 5; i++) exp_words.push_back(model_word(i, f, w));
  endtask

  // Drives one request and records busy/done deviations cycle by cycle (cycle 0 = accept).
  task automatic watch_seq(input logic [27:0] f, input logic [1:0] w, input int hold_until,
                           input int poke_at, input logic [27:0] poke_f, input int rst_at,
                           input int ncyc, input int t1, input int t2,
                           output int busy_bad, output int done_bad, output logic [3:0] rst_obs);
    logic exp_b, exp_d;
    busy_bad = 0; done_bad = 0; rst_obs = 4'hx;
    @(negedge clk);
    freq_in = f; wave_sel = w; start_r = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      exp_b = (c < t1 || (t2 > 0 && c > t1 && c < t2)) && (rst_at == 0 || c <= rst_at);
      exp_d = (c == t1 || c == t2) && rst_at == 0;
      if (m_busy !== exp_b) busy_bad++;
      if (m_done !== exp_d) done_bad++;
      if (rst_at > 0 && c == rst_at + 1) begin
        rst_obs = {m_sclk, m_fsync, m_busy, m_done};
        rst = 1'b0;
      end
      if (rst_at > 0 && c == rst_at) rst = 1'b1;
      if (c == poke_at) begin
        freq_in = poke_f; start_r = 1'b1;
      end
      if (c == hold_until || (poke_at > 0 && c == poke_at + 1)) start_r = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({sclk_d, fsync_d, sdata_d, busy_d, done_d} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_idle cyc%0d got %b want 11000", c,
                 {sclk_d, fsync_d, sdata_d, busy_d, done_d});
      end
      checks++;
      if ({sclk_f, fsync_f, sdata_f, busy_f, done_f} !== 5'b11000) begin
        errors++;
        $display("FAIL reset_idle_fast cyc%0d got %b want 11000", c,
                 {sclk_f, fsync_f, sdata_f, busy_f, done_f});
      end
    end
  endtask

  task automatic test_directed();
    logic [27:0] fv[3] = '{28'h0000001, 28'hFFFFFFF, 28'h0004000};
    logic [1:0]  wv[3] = '{2'd0, 2'd2, 2'd1};
    int bb, db;
    logic [3:0] ro;
    mon_sel = 1'b0;
    for (int v = 0; v < 3; v++) begin
      clear_caps();
      add_model(fv[v], wv[v]);
      watch_seq(fv[v], wv[v], 1, 0, 28'd0, 0, TD + 4, TD, 0, bb, db, ro);
      checks++;
      if (bb != 0 || db != 0) begin
        errors++;
        $display("FAIL directed%0d busy/done bad cycles got %0d/%0d want 0/0", v, bb, db);
      end
      checks++;
      if (cap_words.size() != 5) begin
        errors++;
        $display("FAIL directed%0d frames got %0d want 5", v, cap_words.size());
      end
      for (int i = 0; i < 5 && i < cap_words.size(); i++) begin
        checks++;
        if (cap_words[i] !== exp_words[i] || cap_falls[i] != 16 || cap_low[i] != 33 * HD) begin
          errors++;
          $display("FAIL directed%0d word%0d got %h/%0d falls/%0d low want %h/16/%0d", v, i,
                   cap_words[i], cap_falls[i], cap_low[i], exp_words[i], 33 * HD);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int bb, db;
    logic [3:0] ro;
    mon_sel = 1'b0;
    clear_caps();
    add_model(28'h0000001, 2'd3);
    watch_seq(28'h0000001, 2'd3, 1, 100, 28'h1234567, 0, TD + 4, TD, 0, bb, db, ro);
    checks++;
    if (bb != 0 || db != 0) begin
      errors++;
      $display("FAIL start_ignored busy/done bad cycles got %0d/%0d want 0/0", bb, db);
    end
    checks++;
    if (cap_words.size() != 5) begin
      errors++;
      $display("FAIL start_ignored frames got %0d want 5", cap_words.size());
    end
    for (int i = 0; i < 5 && i < cap_words.size(); i++) begin
      checks++;
      if (cap_words[i] !== exp_words[i]) begin
        errors++;
        $display("FAIL start_ignored word%0d got %h want %h", i, cap_words[i], exp_words[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bb, db;
    logic [3:0] ro;
    logic [27:0] f;
    mon_sel = 1'b0;
    clear_caps();
    watch_seq(28'h0000001, 2'd0, 1, 0, 28'd0, 300, 400, TD, 0, bb, db, ro);
    checks++;
    if (ro !== 4'b1100) begin
      errors++;
      $display("FAIL reset_mid_edge sclk/fsync/busy/done got %b want 1100", ro);
    end
    checks++;
    if (bb != 0 || db != 0) begin
      errors++;
      $display("FAIL reset_mid busy/done bad cycles got %0d/%0d want 0/0", bb, db);
    end
    f = 28'($urandom);
    clear_caps();
    add_model(f, 2'd1);
    watch_seq(f, 2'd1, 1, 0, 28'd0, 0, TD + 4, TD, 0, bb, db, ro);
    checks++;
    if (bb != 0 || db != 0 || cap_words.size() != 5) begin
      errors++;
      $display("FAIL reset_recover busy/done/frames got %0d/%0d/%0d want 0/0/5", bb, db,
               cap_words.size());
    end
    for (int i = 0; i < 5 && i < cap_words.size(); i++) begin
      checks++;
      if (cap_words[i] !== exp_words[i] || cap_falls[i] != 16) begin
        errors++;
        $display("FAIL reset_recover word%0d got %h/%0d falls want %h/16", i, cap_words[i],
                 cap_falls[i], exp_words[i]);
      end
    end
  endtask

  task automatic test_random();
    int bb, db;
    logic [3:0] ro;
    logic [27:0] f;
    logic [1:0] w;
    mon_sel = 1'b1;
    for (int r = 0; r < 4; r++) begin
      f = 28'($urandom);
      w = 2'($urandom_range(0, 3));
      clear_caps();
      add_model(f, w);
      watch_seq(f, w, 1, 0, 28'd0, 0, TF + 4, TF, 0, bb, db, ro);
      checks++;
      if (bb != 0 || db != 0 || cap_words.size() != 5) begin
        errors++;
        $display("FAIL random%0d busy/done/frames got %0d/%0d/%0d want 0/0/5", r, bb, db,
                 cap_words.size());
      end
      for (int i = 0; i < 5 && i < cap_words.size(); i++) begin
        checks++;
        if (cap_words[i] !== exp_words[i] || cap_falls[i] != 16 || cap_low[i] != 33 * HF) begin
          errors++;
          $display("FAIL random%0d word%0d got %h/%0d/%0d want %h/16/%0d", r, i, cap_words[i],
                   cap_falls[i], cap_low[i], exp_words[i], 33 * HF);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int bb, db;
    logic [3:0] ro;
    logic [27:0] f1, f2;
    logic [1:0] w;
    mon_sel = 1'b1;
    f1 = 28'($urandom);
    f2 = 28'($urandom);
    w  = 2'($urandom_range(0, 3));
    clear_caps();
    add_model(f1, w);
    add_model(f2, w);
    // start stays high through the first done cycle; freq changes to f2 for the re-accept.
    watch_seq(f1, w, TF + 1, TF, f2, 0, 2 * TF + 4, TF, 2 * TF, bb, db, ro);
    checks++;
    if (bb != 0 || db != 0) begin
      errors++;
      $display("FAIL back_to_back busy/done bad cycles got %0d/%0d want 0/0", bb, db);
    end
    checks++;
    if (cap_words.size() != 10) begin
      errors++;
      $display("FAIL back_to_back frames got %0d want 10", cap_words.size());
    end
    for (int i = 0; i < 10 && i < cap_words.size(); i++) begin
      checks++;
      if (cap_words[i] !== exp_words[i] || cap_falls[i] != 16 || cap_low[i] != 33 * HF) begin
        errors++;
        $display("FAIL back_to_back word%0d got %h/%0d/%0d want %h/16/%0d", i, cap_words[i],
                 cap_falls[i], cap_low[i], exp_words[i], 33 * HF);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
